// File: rtl/mul_div_pkg.sv
// Shared definitions for the multiplier/divider family.
//  - DEF_WIDTH / DEF_CNT_W : default operand width and matching iteration-counter width
//  - div_state_t           : sequencer states of the sequential divider
//  - cond_neg()            : conditional two's-complement negate (absolute value / sign restore)
package mul_div_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_CNT_W = $clog2(DEF_WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        FIX
    } div_state_t;

    // Negates v when neg is set. Callers pass a zero-extended operand and
    // truncate the result back to their own width, so the result is correct
    // modulo 2^width for any width up to 32. This also covers |min|: negating
    // the most negative value yields the same bit pattern, which read as
    // unsigned is exactly 2^(width-1).
    function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/booth_divider4_if.sv
// Operand/result bundle of the sequential divider.
//  master : requester (drives start/dvd/dvs, observes results and status)
//  slave  : divider   (samples the request, drives quot/rem/busy/done/flags)
interface booth_divider4_if #(
    parameter int WIDTH = mul_div_pkg::DEF_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] rem;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic             ovf;

    modport master (
        output start, dvd, dvs,
        input  quot, rem, busy, done, div_by_zero, ovf
    );

    modport slave (
        input  start, dvd, dvs,
        output quot, rem, busy, done, div_by_zero, ovf
    );
endinterface

// File: rtl/booth_divider4.sv
// Sequential signed two's-complement divider, non-restoring, one quotient bit
// per clock. Quotient truncates toward zero, remainder takes the dividend's sign.
// Ports:
//  clk    : rising-edge clock
//  rst_n  : asynchronous active-low reset (aborts any operation, no done)
//  bus    : booth_divider4_if.slave
//           start/dvd/dvs sampled in IDLE only; quot/rem/div_by_zero/ovf are
//           registered and held, updated together with a one-cycle done pulse;
//           busy high for WIDTH+1 cycles of a non-zero-divisor operation.
module booth_divider4
    import mul_div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    booth_divider4_if.slave      bus
);

    localparam int            CW   = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    div_state_t       state;
    logic [CW-1:0]    count;
    logic [WIDTH:0]   acc;       // partial remainder A, signed WIDTH+1 bits
    logic [WIDTH-1:0] q_reg;     // |dividend| shifting out, quotient bits shifting in
    logic [WIDTH-1:0] m_reg;     // |divisor|, unsigned
    logic             sign_q;
    logic             sign_r;
    logic             ovf_pend;  // min / -1 detected at launch, reported at FIX

    logic [WIDTH-1:0] abs_dvd;
    logic [WIDTH-1:0] abs_dvs;
    logic [WIDTH:0]   a_sh;
    logic [WIDTH:0]   a_new;
    logic [WIDTH:0]   a_fix;
    logic [WIDTH-1:0] quot_fix;
    logic [WIDTH-1:0] rem_fix;
    logic             is_ovf;

    always_comb begin
        abs_dvd  = WIDTH'(cond_neg(32'(bus.dvd), bus.dvd[WIDTH-1]));
        abs_dvs  = WIDTH'(cond_neg(32'(bus.dvs), bus.dvs[WIDTH-1]));
        is_ovf   = (bus.dvd == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.dvs == '1);

        // {A,Q} << 1, then add or subtract M depending on the sign of the
        // previous A. A stays within [-M, M), so WIDTH+1 bits are enough even
        // for M = 2^(WIDTH-1).
        a_sh     = {acc[WIDTH-1:0], q_reg[WIDTH-1]};
        a_new    = acc[WIDTH] ? (a_sh + {1'b0, m_reg}) : (a_sh - {1'b0, m_reg});

        // Final restore of a negative partial remainder.
        a_fix    = acc[WIDTH] ? (acc + {1'b0, m_reg}) : acc;
        quot_fix = WIDTH'(cond_neg(32'(q_reg), sign_q));
        rem_fix  = WIDTH'(cond_neg(32'(a_fix[WIDTH-1:0]), sign_r));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            count           <= '0;
            acc             <= '0;
            q_reg           <= '0;
            m_reg           <= '0;
            sign_q          <= 1'b0;
            sign_r          <= 1'b0;
            ovf_pend        <= 1'b0;
            bus.quot        <= '0;
            bus.rem         <= '0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.div_by_zero <= 1'b0;
            bus.ovf         <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.dvs == '0) begin
                            // Resolved immediately; never becomes busy.
                            bus.quot        <= '1;
                            bus.rem         <= bus.dvd;
                            bus.div_by_zero <= 1'b1;
                            bus.ovf         <= 1'b0;
                            bus.done        <= 1'b1;
                        end else begin
                            q_reg    <= abs_dvd;
                            m_reg    <= abs_dvs;
                            sign_q   <= bus.dvd[WIDTH-1] ^ bus.dvs[WIDTH-1];
                            sign_r   <= bus.dvd[WIDTH-1];
                            ovf_pend <= is_ovf;
                            acc      <= '0;
                            count    <= '0;
                            bus.busy <= 1'b1;
                            state    <= ITER;
                        end
                    end
                end
                ITER: begin
                    acc   <= a_new;
                    q_reg <= {q_reg[WIDTH-2:0], ~a_new[WIDTH]};
                    count <= count + CW'(1);
                    if (count == LAST) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    bus.quot        <= quot_fix;
                    bus.rem         <= rem_fix;
                    bus.ovf         <= ovf_pend;
                    bus.div_by_zero <= 1'b0;
                    bus.done        <= 1'b1;
                    bus.busy        <= 1'b0;
                    count           <= '0;
                    state           <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_divider4.sv
// Self-checking bench for booth_divider4 (WIDTH=4). Expected results are
// pushed to a scoreboard queue at launch and popped when done is seen.
module tb_booth_divider4;

    localparam int W = 4;

    typedef struct packed {
        logic [W-1:0] quot;
        logic [W-1:0] rem;
        logic         dbz;
        logic         ovf;
    } res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    booth_divider4_if #(.WIDTH(W)) bus ();

    booth_divider4 #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    res_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Reference: truncating signed division, remainder follows dividend.
    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        res_t r;
        logic signed [W-1:0] sa;
        logic signed [W-1:0] sb_;
        int ia;
        int ib;
        sa  = a;
        sb_ = b;
        ia  = sa;
        ib  = sb_;
        r   = '0;
        if (ib == 0) begin
            r.quot = '1;
            r.rem  = a;
            r.dbz  = 1'b1;
        end else if (ia == -(1 << (W - 1)) && ib == -1) begin
            r.quot = a;
            r.rem  = '0;
            r.ovf  = 1'b1;
        end else begin
            r.quot = W'(ia / ib);
            r.rem  = W'(ia % ib);
        end
        return r;
    endfunction

    function automatic res_t mk(input logic [W-1:0] q, input logic [W-1:0] r,
                                input logic z, input logic o);
        res_t x;
        x.quot = q;
        x.rem  = r;
        x.dbz  = z;
        x.ovf  = o;
        return x;
    endfunction

    // One-cycle start pulse; returns at the falling edge after the start edge.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b,
                          input res_t e, input bit push);
        @(negedge clk);
        bus.start = 1'b1;
        bus.dvd   = a;
        bus.dvs   = b;
        if (push) sb.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Waits (bounded) for done, counting falling edges and busy-high samples.
    task automatic wait_done(output int cyc, output int bsy);
        cyc = 0;
        bsy = 0;
        while (!bus.done && cyc < 40) begin
            if (bus.busy) bsy++;
            @(negedge clk);
            cyc++;
        end
    endtask

    // Launch, wait, pop the scoreboard and compare. lat counts clock edges
    // from the start edge inclusive up to the edge that raised done.
    task automatic do_divide(input logic [W-1:0] a, input logic [W-1:0] b,
                             input res_t e, input string tag,
                             output int lat, output int bsy);
        res_t exp_r;
        res_t got;
        launch(a, b, e, 1'b1);
        wait_done(lat, bsy);
        lat = lat + 1;
        n_vec++;
        if (bus.done !== 1'b1) begin
            n_bad++;
            $display("FAIL %s done-timeout: got done=%b, expected 1", tag, bus.done);
        end
        exp_r = sb.pop_front();
        got   = {bus.quot, bus.rem, bus.div_by_zero, bus.ovf};
        n_vec++;
        if (got !== exp_r) begin
            n_bad++;
            $display("FAIL %s result: got q=%h r=%h dbz=%b ovf=%b, expected q=%h r=%h dbz=%b ovf=%b",
                     tag, got.quot, got.rem, got.dbz, got.ovf,
                     exp_r.quot, exp_r.rem, exp_r.dbz, exp_r.ovf);
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        bus.dvd   = '0;
        bus.dvs   = '0;
        rst_n     = 1'b0;
        #22;
        n_vec++;
        if ({bus.quot, bus.rem, bus.busy, bus.done, bus.div_by_zero, bus.ovf} !== '0) begin
            n_bad++;
            $display("FAIL reset_state: got q=%h r=%h busy=%b done=%b dbz=%b ovf=%b, expected all 0",
                     bus.quot, bus.rem, bus.busy, bus.done, bus.div_by_zero, bus.ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int lat;
        int bsy;
        do_divide(4'd7, 4'd2, mk(4'd3, 4'd1, 1'b0, 1'b0), "7/2", lat, bsy);
        n_vec++;
        if (lat !== 6) begin
            n_bad++;
            $display("FAIL 7/2 latency: got %0d clocks, expected 6", lat);
        end
        n_vec++;
        if (bsy !== 5) begin
            n_bad++;
            $display("FAIL 7/2 busy_cycles: got %0d, expected 5", bsy);
        end
    endtask

    task automatic test_signs();
        int lat;
        int bsy;
        do_divide(4'h9, 4'h2, mk(4'hD, 4'hF, 1'b0, 1'b0), "-7/2", lat, bsy);
        do_divide(4'h7, 4'hE, mk(4'hD, 4'h1, 1'b0, 1'b0), "7/-2", lat, bsy);
        do_divide(4'h9, 4'hE, mk(4'h3, 4'hF, 1'b0, 1'b0), "-7/-2", lat, bsy);
    endtask

    task automatic test_overflow();
        int lat;
        int bsy;
        do_divide(4'h8, 4'hF, mk(4'h8, 4'h0, 1'b0, 1'b1), "-8/-1", lat, bsy);
        do_divide(4'h6, 4'h3, mk(4'h2, 4'h0, 1'b0, 1'b0), "6/3_after_ovf", lat, bsy);
    endtask

    task automatic test_div_zero();
        int lat;
        int bsy;
        do_divide(4'h5, 4'h0, mk(4'hF, 4'h5, 1'b1, 1'b0), "5/0", lat, bsy);
        n_vec++;
        if (lat !== 1) begin
            n_bad++;
            $display("FAIL 5/0 latency: got %0d clocks, expected 1", lat);
        end
        n_vec++;
        if (bsy !== 0 || bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL 5/0 busy: got %0d busy cycles (busy=%b), expected 0", bsy, bus.busy);
        end
    endtask

    task automatic test_ignore_start();
        int   cyc;
        int   bsy;
        int   extra;
        res_t exp_r;
        res_t got;
        launch(4'd7, 4'd2, mk(4'd3, 4'd1, 1'b0, 1'b0), 1'b1);
        @(negedge clk);
        bus.start = 1'b1;
        bus.dvd   = 4'h5;
        bus.dvs   = 4'h1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.dvd   = 4'hC;
        wait_done(cyc, bsy);
        n_vec++;
        if (bus.done !== 1'b1) begin
            n_bad++;
            $display("FAIL ignore done-timeout: got done=%b, expected 1", bus.done);
        end
        exp_r = sb.pop_front();
        got   = {bus.quot, bus.rem, bus.div_by_zero, bus.ovf};
        n_vec++;
        if (got !== exp_r) begin
            n_bad++;
            $display("FAIL ignore result: got q=%h r=%h, expected q=%h r=%h",
                     got.quot, got.rem, exp_r.quot, exp_r.rem);
        end
        extra = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.done) extra++;
        end
        n_vec++;
        if (extra !== 0) begin
            n_bad++;
            $display("FAIL ignore extra_done: got %0d done pulses, expected 0", extra);
        end
    endtask

    task automatic test_reset_abort();
        int lat;
        int bsy;
        int extra;
        do_divide(4'd7, 4'd3, mk(4'd2, 4'd1, 1'b0, 1'b0), "7/3", lat, bsy);
        launch(4'd7, 4'd2, '0, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({bus.quot, bus.rem, bus.busy, bus.done, bus.div_by_zero, bus.ovf} !== '0) begin
            n_bad++;
            $display("FAIL abort_async: got q=%h r=%h busy=%b done=%b dbz=%b ovf=%b, expected all 0",
                     bus.quot, bus.rem, bus.busy, bus.done, bus.div_by_zero, bus.ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) extra++;
        end
        n_vec++;
        if (extra !== 0) begin
            n_bad++;
            $display("FAIL abort_no_done: got %0d cycles with done/busy, expected 0", extra);
        end
    endtask

    task automatic test_back_to_back();
        int   cyc;
        int   bsy;
        int   extra;
        res_t exp_r;
        res_t got;
        @(negedge clk);
        bus.start = 1'b1;
        bus.dvd   = 4'd3;
        bus.dvs   = 4'd3;
        sb.push_back(mk(4'd1, 4'd0, 1'b0, 1'b0));
        for (int k = 0; k < 3; k++) begin
            wait_done(cyc, bsy);
            n_vec++;
            if (bus.done !== 1'b1) begin
                n_bad++;
                $display("FAIL b2b[%0d] done-timeout: got done=%b, expected 1", k, bus.done);
            end
            if (k > 0) begin
                n_vec++;
                if (cyc + 1 !== 6) begin
                    n_bad++;
                    $display("FAIL b2b[%0d] period: got %0d clocks, expected 6", k, cyc + 1);
                end
            end
            exp_r = sb.pop_front();
            got   = {bus.quot, bus.rem, bus.div_by_zero, bus.ovf};
            n_vec++;
            if (got !== exp_r) begin
                n_bad++;
                $display("FAIL b2b[%0d] result: got q=%h r=%h, expected q=%h r=%h",
                         k, got.quot, got.rem, exp_r.quot, exp_r.rem);
            end
            if (k < 2) sb.push_back(mk(4'd1, 4'd0, 1'b0, 1'b0));
            else       bus.start = 1'b0;
            @(negedge clk);
        end
        extra = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.done) extra++;
            @(negedge clk);
        end
        n_vec++;
        if (extra !== 0) begin
            n_bad++;
            $display("FAIL b2b trailing_done: got %0d pulses, expected 0", extra);
        end
    endtask

    task automatic test_sweep();
        int lat;
        int bsy;
        logic [W-1:0] a;
        logic [W-1:0] b;
        for (int i = 0; i < (1 << W); i++) begin
            for (int j = 0; j < (1 << W); j++) begin
                a = W'(i);
                b = W'(j);
                do_divide(a, b, model(a, b), $sformatf("sweep %h/%h", a, b), lat, bsy);
                n_vec++;
                if (lat !== ((b == '0) ? 1 : 6)) begin
                    n_bad++;
                    $display("FAIL sweep %h/%h latency: got %0d, expected %0d",
                             a, b, lat, (b == '0) ? 1 : 6);
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_signs();
        test_overflow();
        test_div_zero();
        test_ignore_start();
        test_reset_abort();
        test_back_to_back();
        test_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
